// File: rtl/counter_mod_n.sv
// Up/down modulo-(MAX+1) counter with wrap/saturate boundary handling, a one-cycle
// terminal-count pulse and a sticky overflow flag.
// Optional prescaler: define COUNTER_PRESCALE_EN to step only once every PRE_DIV
// enabled cycles. Without the macro every enabled cycle is a step.
module counter_mod_n #(
    parameter int unsigned N       = 8,
    parameter int unsigned MAX     = 255,
    parameter int unsigned PRE_DIV = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         sat_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         clr_ovf_i,
    output logic [N-1:0] count_o,
    output logic         tc_o,
    output logic         ovf_o
);

    localparam logic [N-1:0] MaxVal = N'(MAX);
    localparam logic [N-1:0] One    = N'(1);

    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         ovf_q, ovf_d;
    logic         step;
    logic         at_bound;
    logic         bound_evt;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PhW      = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(PRE_DIV - 1);

    logic [PhW-1:0] phase_q, phase_d;

    // Phase advances on enabled cycles; load restarts the prescale interval.
    always_comb begin
        phase_d = phase_q;
        if (load_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
        end
    end

    assign step = en_i && !load_i && (phase_q == PhLast);

    // Prescaler phase register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    logic unused_pre_div;
    assign unused_pre_div = (PRE_DIV > 1);

    assign step = en_i && !load_i;
`endif

    // A step at the top going up, or at zero going down, is a boundary event.
    assign at_bound  = up_i ? (count_q == MaxVal) : (count_q == '0);
    assign bound_evt = step && at_bound;

    // Next-state: load beats step; boundary either wraps or holds depending on sat.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
        end else if (step) begin
            if (bound_evt) begin
                if (!sat_i) begin
                    count_d = up_i ? '0 : MaxVal;
                end
            end else begin
                count_d = up_i ? (count_q + One) : (count_q - One);
            end
        end
        tc_d  = bound_evt;
        // Setting wins over a coincident clear.
        ovf_d = bound_evt || (ovf_q && !clr_ovf_i);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench for counter_mod_n (N=4, MAX=9, no prescaler): directed
// scenarios followed by random stimulus, compared against an arithmetic model.
module tb_counter_mod_n;

    localparam int unsigned N   = 4;
    localparam int unsigned MAX = 9;

    logic         clk = 1'b0;
    logic         rst, en, up, sat, load, clr;
    logic [N-1:0] lv;
    logic [N-1:0] count;
    logic         tc, ovf;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;

    counter_mod_n #(.N(N), .MAX(MAX), .PRE_DIV(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .up_i       (up),
        .sat_i      (sat),
        .load_i     (load),
        .load_val_i (lv),
        .clr_ovf_i  (clr),
        .count_o    (count),
        .tc_o       (tc),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the current inputs, clock the DUT, compare.
    task automatic tick(input string tag);
        int evt;
        if (rst) begin
            m_count = 0; m_tc = 0; m_ovf = 0;
        end else if (load) begin
            m_count = (int'(lv) > MAX) ? MAX : int'(lv);
            m_tc    = 0;
            m_ovf   = m_ovf & ~int'(clr);
        end else if (en) begin
            evt = up ? int'(m_count == MAX) : int'(m_count == 0);
            if (!(evt && sat))
                m_count = (m_count + (up ? 1 : MAX)) % (MAX + 1);
            m_tc  = evt;
            m_ovf = evt | (m_ovf & ~int'(clr));
        end else begin
            m_tc  = 0;
            m_ovf = m_ovf & ~int'(clr);
        end
        @(posedge clk);
        #1;
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".tc"},    int'(tc),    m_tc);
        chk({tag, ".ovf"},   int'(ovf),   m_ovf);
    endtask

    task automatic idle();
        rst = 0; en = 0; up = 1; sat = 0; load = 0; lv = '0; clr = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        tick("reset");
        tick("reset2");
        chk("reset_const", int'({count, tc, ovf}), 0);

        // Count up with wrap for 12 cycles: 1..9,0,1,2
        idle();
        en = 1;
        for (int i = 0; i < 12; i++) begin
            tick("up_wrap");
            chk("up_wrap_seq", int'(count), (i + 1) % 10);
            chk("up_wrap_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        chk("up_wrap_ovf", int'(ovf), 1);

        // Load above MAX clamps; then saturate at MAX with tc every cycle
        idle();
        load = 1; lv = 4'd15;
        tick("load_clamp");
        chk("load_clamp_const", int'(count), 9);
        idle();
        en = 1; up = 1; sat = 1;
        for (int i = 0; i < 3; i++) begin
            tick("sat_top");
            chk("sat_top_const", int'({count, tc}), (9 << 1) | 1);
        end

        // Clear ovf, then wrap down from 0, then clear coinciding with an event
        idle();
        clr = 1;
        tick("clr_ovf");
        chk("clr_ovf_const", int'(ovf), 0);
        idle();
        load = 1; lv = 4'd0;
        tick("load0");
        idle();
        en = 1; up = 0;
        tick("down_wrap");
        chk("down_wrap_const", int'({count, tc}), (9 << 1) | 1);
        idle();
        load = 1; lv = 4'd0;
        tick("load0b");
        idle();
        en = 1; up = 0; sat = 1; clr = 1;
        tick("set_beats_clr");
        chk("set_beats_clr_const", int'({count, tc, ovf}), 3);

        // Load beats step; reset beats load
        idle();
        load = 1; lv = 4'd5;
        tick("load5");
        load = 1; lv = 4'd2; en = 1;
        tick("load_over_step");
        chk("load_over_step_const", int'({count, tc}), 2 << 1);
        rst = 1; load = 1; lv = 4'd7;
        tick("rst_over_load");
        chk("rst_over_load_const", int'(count), 0);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            sat  = $urandom_range(0, 1) == 1;
            clr  = ($urandom_range(0, 7) == 0);
            lv   = N'($urandom_range(0, 15));
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_mod_n.md
COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 Parameter N, 8, counter width in bits (1..32).
REQ-002 Parameter MAX, 255, terminal value; legal range 0..2^N-1; count range is 0..MAX.
REQ-003 Parameter PRE_DIV, 4, prescaler divide ratio (2..256); used only with COUNTER_PRESCALE_EN.
REQ-004 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  count enable; one step per enabled cycle, or per prescaler tick when prescaling is compiled in.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement; sampled each cycle.
REQ-008 sat  input  1  boundary mode; 0 = wrap, 1 = saturate; sampled each cycle.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  N  value loaded when load=1.
REQ-011 clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 count  output  N  current count, registered.
REQ-013 tc  output  1  registered one-cycle pulse; boundary event occurred on the previous edge.
REQ-014 ovf  output  1  sticky flag; set on any boundary event.

Function
REQ-015 Priority at each edge SHALL be rst > load > step > hold.
REQ-016 load=1: count SHALL become min(load_val, MAX) on the next edge; no step, no tc, ovf unaffected except by clr_ovf.
REQ-017 Step: up=1 and count<MAX gives count+1; up=0 and count>0 gives count-1; all arithmetic modulo MAX+1, never modulo 2^N.
REQ-018 Boundary event: a step requested with up=1 at count==MAX, or with up=0 at count==0.
REQ-019 At a boundary event with sat=0, count SHALL wrap: MAX->0 counting up, 0->MAX counting down.
REQ-020 At a boundary event with sat=1, count SHALL hold at MAX or 0 respectively.
REQ-021 tc SHALL be 1 for exactly the one cycle following each boundary event (wrap or saturate); consecutive events SHALL give tc high on consecutive cycles.
REQ-022 ovf SHALL set on the edge of a boundary event and hold until clr_ovf=1; when set and clear coincide, set SHALL win.
REQ-023 en=0 with load=0: count, tc=0, and prescaler state SHALL hold; ovf changes only via clr_ovf.
REQ-024 MAX=0: every enabled step is a boundary event; count stays 0.
REQ-025 Direction or mode changes take effect on the same edge they are sampled; there is no pipeline latency.

Reset
REQ-026 rst=1 at an edge SHALL set count=0, tc=0, ovf=0, and prescaler phase=0, overriding load, en, and clr_ovf.
REQ-027 Asserting rst mid-count SHALL discard any pending tick or event; counting resumes on the first edge with rst=0.

Configuration
REQ-028 With macro COUNTER_PRESCALE_EN defined:
- An internal phase counter, 0..PRE_DIV-1, advances on each en=1 cycle.
- A step occurs only on the en cycle where phase==PRE_DIV-1; phase then returns to 0.
- load SHALL reset phase to 0.
REQ-029 Without COUNTER_PRESCALE_EN: no prescaler logic; every en=1 cycle is a step; PRE_DIV is ignored.

Verification (N=4, MAX=9, no prescale unless stated)
REQ-030 rst, then en=1, up=1, sat=0 for 12 cycles -> count 1..9,0,1,2; tc high only the cycle after 9->0; ovf=1 thereafter.
REQ-031 load_val=15, load=1 -> count=9; then up=1, sat=1, en=1 for 3 cycles -> count stays 9, tc high 3 consecutive cycles.
REQ-032 count=0, up=0, sat=0, en=1 -> count=9, tc pulse; then clr_ovf=1 together with another boundary event -> ovf stays 1.
REQ-033 count=5, load=1 with load_val=2 and en=1 in the same cycle -> count=2 and no tc; rst=1 together with load=1 -> count=0.
REQ-034 COUNTER_PRESCALE_EN, PRE_DIV=4, en=1 for 8 cycles from reset -> count=1 after cycle 4, count=2 after cycle 8; en gaps stretch the interval.
